xor_skew_meas_ctrl: RTL
=======================

Name: xor_skew_meas_ctrl

Overview:
Measurement sequencer for the dual inverter-chain skew monitor. It enables the chains, lets the synchronizer settle, then opens a programmable gate window. During the window it counts rising edges and high cycles of the chains' XOR mismatch output, and reports the result with a done pulse. It sits between the chain block's output_XOR and the register/readout logic, in the sys_clk domain.

Parameters:
CNT_W, 16, width of the pulse and high-time result counters
WIN_W, 16, width of the gate-window length input
SETTLE_CYC, 8, cycles between chain enable and window open (minimum 1)
SYNC_STAGES, 2, flops in the xor_in synchronizer (minimum 2)

Ports:
sys_clk  in  1  system clock, all logic on its rising edge
sys_rst_n  in  1  synchronous active-low reset
start  in  1  level-sampled run request, honoured only in IDLE
abort  in  1  cancel the current run, any state
win_len  in  WIN_W  gate window length in sys_clk cycles, latched at start
xor_in  in  1  asynchronous mismatch input from chain output_XOR
chain_en  out  1  enable to the inverter chains
busy  out  1  high in every state except IDLE
done  out  1  one-cycle pulse when a run completes normally
pulse_cnt  out  CNT_W  rising edges of synced xor_in seen in the window
high_cnt  out  CNT_W  window cycles with synced xor_in high
overflow  out  1  a counter saturated during the last run

Behaviour:
- Reset (sys_rst_n=0 at an edge): state=IDLE; chain_en, busy, done and overflow = 0; pulse_cnt and high_cnt = 0; synchronizer and edge-detect flops = 0.
- xor_in passes through a SYNC_STAGES-flop synchronizer. Only the synced value xs is used.
- States: IDLE, SETTLE, MEASURE, DONE.
- IDLE: start=1 at edge k, with abort=0 at that edge, moves to SETTLE after edge k. The same edge latches win_len into win_r, clears both counters and overflow, and loads the settle counter.
- SETTLE: chain_en=1 and busy=1. Lasts exactly SETTLE_CYC cycles, then goes to MEASURE. On the last SETTLE edge, prev is loaded with xs, so a level that is already high does not count as an edge.
- If win_r=0, SETTLE goes straight to DONE. Both counts stay 0.
- MEASURE: lasts exactly win_r cycles, then goes to DONE. On each MEASURE edge:
  - if xs=1, high_cnt increments;
  - if xs=1 and prev=0, pulse_cnt increments;
  - prev is then updated to xs.
- Saturation: a counter already at all-ones holds its value and sets overflow. overflow stays set until the next accepted start.
- DONE: one cycle. done=1, busy=1, chain_en=0. Then IDLE.
- Timing: chain_en is high in SETTLE and MEASURE only.
- Latency: with start accepted at edge k, done is high in the cycle after edge k+SETTLE_CYC+win_r.
- Results hold in IDLE until the next accepted start.
- abort=1 at any edge in SETTLE, MEASURE or DONE: go to IDLE next cycle with chain_en=0, busy=0, done=0. Partial counts and overflow are retained. abort takes priority over every other transition, including start in IDLE.
- start while busy is ignored. win_len changes while busy have no effect.
- Reset mid-run behaves identically to the reset from power-on.

Test Plan:
- xor_in held 0, SETTLE_CYC=8, win_len=16, start at edge 10 -> chain_en high for 24 cycles; done pulse in the cycle after edge 34; pulse_cnt=0, high_cnt=0, overflow=0.
- xor_in high 1 cycle in every 4 (synchronous to sys_clk), win_len=16 -> pulse_cnt=4, high_cnt=4, done 1 cycle wide, busy falls the cycle after done.
- xor_in held 1 from before start, win_len=100 -> pulse_cnt=0 (no edge counted for the pre-existing level), high_cnt=100.
- CNT_W=4, xor_in held 1, win_len=40 -> high_cnt=15, overflow=1; the next start with xor_in=0 clears overflow to 0.
- abort asserted 5 cycles into MEASURE; a start pulse in the middle of SETTLE -> the mid-SETTLE start is ignored; after abort the next cycle shows IDLE, chain_en=0, no done pulse, partial counts retained.
- win_len=0 -> done in the cycle after edge k+SETTLE_CYC with both counts 0; sys_rst_n low during MEASURE -> all outputs 0 the next cycle and the FSM is in IDLE.

Source files
------------

// File: rtl/xor_skew_meas_ctrl.sv
// xor_skew_meas_ctrl: sequences chain enable, settle and gated XOR mismatch counting
module xor_skew_meas_ctrl #(
  parameter int CNT_W       = 16,
  parameter int WIN_W       = 16,
  parameter int SETTLE_CYC  = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic             sys_clk,
  input  logic             sys_rst_n,
  input  logic             start,
  input  logic             abort,
  input  logic [WIN_W-1:0] win_len,
  input  logic             xor_in,
  output logic             chain_en,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] pulse_cnt,
  output logic [CNT_W-1:0] high_cnt,
  output logic             overflow
);
  localparam int SET_W = SETTLE_CYC > 1 ? $clog2(SETTLE_CYC) : 1;
  typedef enum logic [1:0] {IDLE, SETTLE, MEASURE, DONE} state_t;
  state_t                 r_state;
  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_prev;
  logic [SET_W-1:0]       r_settle;
  logic [WIN_W-1:0]       r_win;
  logic [WIN_W-1:0]       r_mcnt;
  logic                   r_chain_en;
  logic                   r_busy;
  logic                   r_done;
  logic                   r_overflow;
  logic [CNT_W-1:0]       r_pulse;
  logic [CNT_W-1:0]       r_high;
  logic                   w_xs;
  logic                   w_rise;
  assign w_xs      = r_sync[SYNC_STAGES-1];
  assign w_rise    = w_xs & ~r_prev;
  assign chain_en  = r_chain_en;
  assign busy      = r_busy;
  assign done      = r_done;
  assign pulse_cnt = r_pulse;
  assign high_cnt  = r_high;
  assign overflow  = r_overflow;
  // bring the asynchronous mismatch level into sys_clk
  always_ff @(posedge sys_clk)
    if (!sys_rst_n) r_sync <= '0;
    else r_sync <= {r_sync[SYNC_STAGES-2:0], xor_in};
  // run sequencer: settle count, window count, saturating result counters
  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      r_state    <= IDLE;
      r_prev     <= 1'b0;
      r_settle   <= '0;
      r_win      <= '0;
      r_mcnt     <= '0;
      r_chain_en <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_overflow <= 1'b0;
      r_pulse    <= '0;
      r_high     <= '0;
    end else if (abort) begin
      r_state    <= IDLE;
      r_chain_en <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      case (r_state)
        IDLE: if (start) begin
          r_state    <= SETTLE;
          r_win      <= win_len;
          r_pulse    <= '0;
          r_high     <= '0;
          r_overflow <= 1'b0;
          r_settle   <= SET_W'(SETTLE_CYC - 1);
          r_chain_en <= 1'b1;
          r_busy     <= 1'b1;
        end
        SETTLE: if (r_settle == '0) begin
          r_prev <= w_xs;
          r_mcnt <= r_win - WIN_W'(1);
          if (r_win == '0) begin
            r_state    <= DONE;
            r_chain_en <= 1'b0;
            r_done     <= 1'b1;
          end else r_state <= MEASURE;
        end else r_settle <= r_settle - SET_W'(1);
        MEASURE: begin
          r_prev <= w_xs;
          if (w_xs) begin
            if (&r_high) r_overflow <= 1'b1;
            else r_high <= r_high + CNT_W'(1);
          end
          if (w_rise) begin
            if (&r_pulse) r_overflow <= 1'b1;
            else r_pulse <= r_pulse + CNT_W'(1);
          end
          if (r_mcnt == '0) begin
            r_state    <= DONE;
            r_chain_en <= 1'b0;
            r_done     <= 1'b1;
          end else r_mcnt <= r_mcnt - WIN_W'(1);
        end
        DONE: begin
          r_state <= IDLE;
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
        end
        default: r_state <= IDLE;
      endcase
    end
  end
endmodule
